// File: rtl/narnet_rom_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one synchronous weights ROM.
// Define NARNET_ARB_BURST_EN to let a locked requester hold the ROM for up to BURST_MAX grants.
module narnet_rom_arbiter #(
    parameter int NREQ      = 4,
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int BURST_MAX = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    input  logic [NREQ-1:0]      lock_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [AW-1:0]        rom_addr_o,
    input  logic [DW-1:0]        rom_data_i,
    output logic [NREQ-1:0]      rd_valid_o,
    output logic [DW-1:0]        rd_data_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic            grant_any;
    logic [PW-1:0]   cand_idx;
    int              cand;

    logic            s1_vld_q;
    logic [NREQ-1:0] s1_own_q;
    logic [NREQ-1:0] rd_valid_q;
    logic [DW-1:0]   rd_data_q;

    logic [AW-1:0]   addr_sel [NREQ];

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : PW'(int'(i) + 1);
    endfunction

    // First requesting index at or above ptr, wrapping to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(ptr_q) + k) % NREQ;
            cand_idx = PW'(cand);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign grant_any = rst_ni && enable_i && win_found;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign gnt_o[gi]    = grant_any && (win_idx == PW'(gi));
        assign addr_sel[gi] = gnt_o[gi] ? addr_i[gi*AW +: AW] : '0;
    end

    always_comb begin
        rom_addr_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            rom_addr_o = rom_addr_o | addr_sel[k];
        end
    end

`ifdef NARNET_ARB_BURST_EN
    localparam int CW = $clog2(BURST_MAX + 1);

    logic [CW-1:0] bcnt_q, bcnt_d, bcnt_inc;
    logic [PW-1:0] bown_q, bown_d;
    logic          bown_vld_q, bown_vld_d;

    // Keeping ptr on the owner is enough to make it win again; the counter bounds the hold.
    always_comb begin
        ptr_d      = ptr_q;
        bcnt_d     = bcnt_q;
        bown_d     = bown_q;
        bown_vld_d = bown_vld_q;
        bcnt_inc   = (bown_vld_q && (bown_q == win_idx)) ? bcnt_q + 1'b1 : CW'(1);
        if (grant_any) begin
            if (lock_i[win_idx] && (int'(bcnt_inc) < BURST_MAX)) begin
                ptr_d      = win_idx;
                bcnt_d     = bcnt_inc;
                bown_d     = win_idx;
                bown_vld_d = 1'b1;
            end else begin
                ptr_d      = next_idx(win_idx);
                bcnt_d     = '0;
                bown_d     = '0;
                bown_vld_d = 1'b0;
            end
        end else if (bown_vld_q && !req_i[bown_q]) begin
            ptr_d      = next_idx(bown_q);
            bcnt_d     = '0;
            bown_d     = '0;
            bown_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bcnt_q     <= '0;
            bown_q     <= '0;
            bown_vld_q <= 1'b0;
        end else begin
            bcnt_q     <= bcnt_d;
            bown_q     <= bown_d;
            bown_vld_q <= bown_vld_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = next_idx(win_idx);
        end
    end
`endif

    // Stage 1 tracks the address the ROM is reading; stage 2 captures its data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_own_q   <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_vld_q   <= grant_any;
            s1_own_q   <= gnt_o;
            rd_valid_q <= s1_vld_q ? s1_own_q : '0;
            if (s1_vld_q) begin
                rd_data_q <= rom_data_i;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule
